magnitude_peak_detector: RTL and testbench

//  Downstream consumer of the magnitude stage: takes the per-bin magnitude stream (data_out/data_out_ready)

---
 rtl/magnitude_peak_detector_pkg.sv | 40 ++++
 rtl/magnitude_peak_detector_frame_bin_counter.sv | 55 +++++
 rtl/magnitude_peak_detector.sv | 168 ++++++++++++++++
 tb/tb_magnitude_peak_detector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/magnitude_peak_detector_pkg.sv
// -----------------------------------------------------------------------------
// rmx_peak_pkg
// Shared definitions for the magnitude peak detector.
//   - Width helpers that derive the bin index and frame sum widths from the
//     frame length and the magnitude width.
//   - peak_result_t : one result record {mag, bin, sum} for the default
//     configuration (17-bit magnitudes, 512-bin frames). Consumers that use
//     the default build can carry results around in this type.
// No ports (package).
// -----------------------------------------------------------------------------
package rmx_peak_pkg;

    localparam int DEF_DATA_IN_BITS = 17;
    localparam int DEF_FRAME_LEN    = 512;

    // Width of a bin index able to address FRAME_LEN bins (at least 1 bit).
    function automatic int calc_bin_bits(input int frame_len);
        if (frame_len > 1) begin
            return $clog2(frame_len);
        end else begin
            return 1;
        end
    endfunction

    // A frame sum of FRAME_LEN unsigned values cannot exceed
    // 2^BIN_BITS * (2^DATA_BITS - 1), so DATA_BITS + BIN_BITS never overflows.
    function automatic int calc_sum_bits(input int data_bits, input int frame_len);
        return data_bits + calc_bin_bits(frame_len);
    endfunction

    localparam int DEF_BIN_BITS = calc_bin_bits(DEF_FRAME_LEN);
    localparam int DEF_SUM_BITS = calc_sum_bits(DEF_DATA_IN_BITS, DEF_FRAME_LEN);

    typedef struct packed {
        logic [DEF_DATA_IN_BITS-1:0] mag;
        logic [DEF_BIN_BITS-1:0]     bin;
        logic [DEF_SUM_BITS-1:0]     sum;
    } peak_result_t;

endpackage

// File: rtl/magnitude_peak_detector_frame_bin_counter.sv
// -----------------------------------------------------------------------------
// frame_bin_counter
// Tracks which bin of the current frame the next accepted sample belongs to.
// Counts accepted samples, wraps after bin FRAME_LEN-1, and restarts on request.
// A restart that coincides with an accepted sample makes that sample bin 0,
// so the count continues from 1.
// Ports:
//   clk        in   1         clock (posedge)
//   rst        in   1         synchronous reset, active-low
//   i_accept   in   1         a sample is consumed this cycle
//   i_restart  in   1         discard the partial frame
//   o_bin      out  BIN_BITS  bin index of a sample accepted this cycle
//   o_last_bin out  1         o_bin is the final bin of the frame
// -----------------------------------------------------------------------------
module frame_bin_counter #(
    parameter int FRAME_LEN = 512,
    parameter int BIN_BITS  = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_accept,
    input  logic                i_restart,
    output logic [BIN_BITS-1:0] o_bin,
    output logic                o_last_bin
);

    localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(FRAME_LEN - 1);

    logic [BIN_BITS-1:0] r_count;

    // Bin counter: reset, restart, wrap at the last bin, hold on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= {BIN_BITS{1'b0}};
        end else if (i_restart) begin
            if (i_accept) begin
                r_count <= BIN_BITS'(1);
            end else begin
                r_count <= {BIN_BITS{1'b0}};
            end
        end else if (i_accept) begin
            if (r_count == LAST_BIN) begin
                r_count <= {BIN_BITS{1'b0}};
            end else begin
                r_count <= r_count + BIN_BITS'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_bin      = r_count;
    assign o_last_bin = (r_count == LAST_BIN);

endmodule

// File: rtl/magnitude_peak_detector.sv
// -----------------------------------------------------------------------------
// magnitude_peak_detector
// Consumes the per-bin magnitude stream in frames of FRAME_LEN bins and, one
// clock after the last bin of a frame is accepted, publishes the frame's peak
// magnitude, the bin where it first occurred, and the sum of all magnitudes.
// Results are held between frames; peak_out_ready pulses for one cycle.
// Optional feature: define PEAK_THRESHOLD_EN to add the threshold input and
// the peak_above_thr result flag (peak >= threshold, threshold taken on the
// last-bin accept edge).
// Ports:
//   clk             in   1             clock (posedge)
//   rst             in   1             synchronous reset, active-low
//   data_in_ready   in   1             data_in valid this cycle
//   data_in         in   DATA_IN_BITS  unsigned magnitude
//   frame_restart   in   1             discard partial frame, restart at bin 0
//   peak_out_ready  out  1             results updated this cycle
//   peak_mag        out  DATA_IN_BITS  peak magnitude of last frame
//   peak_bin        out  BIN_BITS      bin of peak_mag (earliest on ties)
//   frame_sum       out  SUM_BITS      sum of last frame's magnitudes
//   threshold       in   DATA_IN_BITS  (PEAK_THRESHOLD_EN only)
//   peak_above_thr  out  1             (PEAK_THRESHOLD_EN only)
// -----------------------------------------------------------------------------
module magnitude_peak_detector
    import rmx_peak_pkg::*;
#(
    parameter int DATA_IN_BITS = 17,
    parameter int FRAME_LEN    = 512,
    parameter int BIN_BITS     = calc_bin_bits(FRAME_LEN),
    parameter int SUM_BITS     = calc_sum_bits(DATA_IN_BITS, FRAME_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_in_ready,
    input  logic [DATA_IN_BITS-1:0] data_in,
    input  logic                    frame_restart,
    output logic                    peak_out_ready,
    output logic [DATA_IN_BITS-1:0] peak_mag,
    output logic [BIN_BITS-1:0]     peak_bin,
    output logic [SUM_BITS-1:0]     frame_sum
`ifdef PEAK_THRESHOLD_EN
    ,
    input  logic [DATA_IN_BITS-1:0] threshold,
    output logic                    peak_above_thr
`endif
);

    typedef struct packed {
        logic [DATA_IN_BITS-1:0] mag;
        logic [BIN_BITS-1:0]     bin;
        logic [SUM_BITS-1:0]     sum;
    } frame_result_t;

    logic [BIN_BITS-1:0]     w_bin;
    logic                    w_last_bin;
    logic                    w_first_bin;
    logic                    w_last_accept;
    logic [DATA_IN_BITS-1:0] w_cand_mag;
    logic [BIN_BITS-1:0]     w_cand_bin;
    logic [SUM_BITS-1:0]     w_cand_sum;

    logic [DATA_IN_BITS-1:0] r_max;
    logic [BIN_BITS-1:0]     r_max_bin;
    logic [SUM_BITS-1:0]     r_sum;
    frame_result_t           r_res;
    logic                    r_peak_ready;

    frame_bin_counter #(
        .FRAME_LEN (FRAME_LEN),
        .BIN_BITS  (BIN_BITS)
    ) u_bin_counter (
        .clk        (clk),
        .rst        (rst),
        .i_accept   (data_in_ready),
        .i_restart  (frame_restart),
        .o_bin      (w_bin),
        .o_last_bin (w_last_bin)
    );

    assign w_first_bin   = (w_bin == {BIN_BITS{1'b0}});
    // A restart on the last bin swallows the frame: no result is published.
    assign w_last_accept = data_in_ready & w_last_bin & ~frame_restart;

    // Running max/index/sum including the current sample; bin 0 seeds all three.
    always_comb begin
        w_cand_mag = r_max;
        w_cand_bin = r_max_bin;
        w_cand_sum = r_sum;
        if (w_first_bin || (data_in > r_max)) begin
            w_cand_mag = data_in;
            w_cand_bin = w_bin;
        end else begin
            w_cand_mag = r_max;
            w_cand_bin = r_max_bin;
        end
        if (w_first_bin) begin
            w_cand_sum = SUM_BITS'(data_in);
        end else begin
            w_cand_sum = r_sum + SUM_BITS'(data_in);
        end
    end

    // Running accumulators; a restart with a valid sample seeds a new bin 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_max     <= {DATA_IN_BITS{1'b0}};
            r_max_bin <= {BIN_BITS{1'b0}};
            r_sum     <= {SUM_BITS{1'b0}};
        end else if (frame_restart) begin
            if (data_in_ready) begin
                r_max     <= data_in;
                r_max_bin <= {BIN_BITS{1'b0}};
                r_sum     <= SUM_BITS'(data_in);
            end else begin
                r_max     <= {DATA_IN_BITS{1'b0}};
                r_max_bin <= {BIN_BITS{1'b0}};
                r_sum     <= {SUM_BITS{1'b0}};
            end
        end else if (data_in_ready) begin
            r_max     <= w_cand_mag;
            r_max_bin <= w_cand_bin;
            r_sum     <= w_cand_sum;
        end else begin
            r_max     <= r_max;
            r_max_bin <= r_max_bin;
            r_sum     <= r_sum;
        end
    end

    // Result registers: capture the completed frame and pulse ready once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_res        <= '{mag: {DATA_IN_BITS{1'b0}}, bin: {BIN_BITS{1'b0}}, sum: {SUM_BITS{1'b0}}};
            r_peak_ready <= 1'b0;
        end else begin
            r_peak_ready <= w_last_accept;
            if (w_last_accept) begin
                r_res <= '{mag: w_cand_mag, bin: w_cand_bin, sum: w_cand_sum};
            end else begin
                r_res <= r_res;
            end
        end
    end

    assign peak_out_ready = r_peak_ready;
    assign peak_mag       = r_res.mag;
    assign peak_bin       = r_res.bin;
    assign frame_sum      = r_res.sum;

`ifdef PEAK_THRESHOLD_EN
    logic r_above_thr;

    // Threshold flag registered alongside the other results.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_above_thr <= 1'b0;
        end else if (w_last_accept) begin
            r_above_thr <= (w_cand_mag >= threshold);
        end else begin
            r_above_thr <= r_above_thr;
        end
    end

    assign peak_above_thr = r_above_thr;
`else
    // Threshold comparison not built in this configuration.
`endif

endmodule

// File: tb/tb_magnitude_peak_detector.sv
// -----------------------------------------------------------------------------
// Bench for magnitude_peak_detector with FRAME_LEN=8, DATA_IN_BITS=17.
// A frame-level model (queue of accepted samples, max/sum computed when the
// queue holds a full frame) predicts outputs; a compare process checks them
// every cycle, and hand-computed literals pin each scenario's result records.
// -----------------------------------------------------------------------------
module tb_magnitude_peak_detector;

    localparam int DW = 17;
    localparam int FL = 8;
    localparam int BW = 3;
    localparam int SW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          data_in_ready = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          frame_restart = 1'b0;
    logic          peak_out_ready;
    logic [DW-1:0] peak_mag;
    logic [BW-1:0] peak_bin;
    logic [SW-1:0] frame_sum;
`ifdef PEAK_THRESHOLD_EN
    logic [DW-1:0] threshold = '0;
    logic          peak_above_thr;
`endif

    magnitude_peak_detector #(
        .DATA_IN_BITS (DW),
        .FRAME_LEN    (FL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in_ready  (data_in_ready),
        .data_in        (data_in),
        .frame_restart  (frame_restart),
        .peak_out_ready (peak_out_ready),
        .peak_mag       (peak_mag),
        .peak_bin       (peak_bin),
        .frame_sum      (frame_sum)
`ifdef PEAK_THRESHOLD_EN
        ,
        .threshold      (threshold),
        .peak_above_thr (peak_above_thr)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [DW-1:0] mq[$];
    logic          exp_rdy = 1'b0;
    int            exp_mag = 0;
    int            exp_bin = 0;
    longint        exp_sum = 0;
    logic          exp_thr = 1'b0;

    always @(posedge clk) begin : model
        int     m;
        int     b;
        longint s;
        exp_rdy = 1'b0;
        if (!rst) begin
            mq.delete();
            exp_mag = 0;
            exp_bin = 0;
            exp_sum = 0;
            exp_thr = 1'b0;
        end else begin
            if (frame_restart) mq.delete();
            if (data_in_ready) mq.push_back(data_in);
            if (mq.size() == FL) begin
                m = int'(mq[0]);
                b = 0;
                s = 0;
                foreach (mq[i]) begin
                    s += longint'(mq[i]);
                    if (int'(mq[i]) > m) begin
                        m = int'(mq[i]);
                        b = i;
                    end
                end
                exp_mag = m;
                exp_bin = b;
                exp_sum = s;
                exp_rdy = 1'b1;
`ifdef PEAK_THRESHOLD_EN
                exp_thr = (m >= int'(threshold));
`endif
                mq.delete();
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ready", longint'(peak_out_ready), longint'(exp_rdy));
        chk("peak_mag", longint'(peak_mag), longint'(exp_mag));
        chk("peak_bin", longint'(peak_bin), longint'(exp_bin));
        chk("frame_sum", longint'(frame_sum), exp_sum);
`ifdef PEAK_THRESHOLD_EN
        chk("peak_above_thr", longint'(peak_above_thr), longint'(exp_thr));
`endif
    end

    // ---------------- pulse recorder ----------------
    typedef struct {
        int     mag;
        int     bin;
        longint sum;
        int     at;
        logic   thr;
    } pulse_t;
    pulse_t pq[$];

    always @(negedge clk) begin : recorder
        pulse_t p;
        if (peak_out_ready === 1'b1) begin
            p.mag = int'(peak_mag);
            p.bin = int'(peak_bin);
            p.sum = longint'(frame_sum);
            p.at  = cyc;
`ifdef PEAK_THRESHOLD_EN
            p.thr = peak_above_thr;
`else
            p.thr = 1'b0;
`endif
            pq.push_back(p);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic v, input int d, input logic r);
        @(negedge clk);
        data_in_ready = v;
        data_in       = DW'(d);
        frame_restart = r;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 0, 1'b0);
    endtask

    task automatic check_pulse(input string tag, input int idx, input int m, input int b, input longint s);
        if (idx < pq.size()) begin
            chk({tag, "_mag"}, pq[idx].mag, m);
            chk({tag, "_bin"}, pq[idx].bin, b);
            chk({tag, "_sum"}, pq[idx].sum, s);
        end else begin
            chk({tag, "_present"}, pq.size(), idx + 1);
        end
    endtask

    int t1_data[8] = '{3, 9, 1, 7, 9, 2, 0, 5};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", peak_out_ready, 0);
        chk("rst_mag", peak_mag, 0);
        chk("rst_bin", peak_bin, 0);
        chk("rst_sum", frame_sum, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        // 1: contiguous frame with a tie on the peak
        foreach (t1_data[i]) send(1'b1, t1_data[i], 1'b0);
        idle(2);
        chk("t1_count", pq.size(), 1);
        check_pulse("t1", 0, 9, 1, 36);
        pq.delete();

        // 2: back-to-back frames, second at full scale
        foreach (t1_data[i]) send(1'b1, t1_data[i], 1'b0);
        repeat (FL) send(1'b1, 'h1FFFF, 1'b0);
        idle(2);
        chk("t2_count", pq.size(), 2);
        check_pulse("t2a", 0, 9, 1, 36);
        check_pulse("t2b", 1, 131071, 0, 1048568);
        if (pq.size() >= 2) chk("t2_spacing", pq[1].at - pq[0].at, 8);
        pq.delete();

        // 3: ascending frame with random gaps
        for (int i = 1; i <= FL; i++) begin
            idle(int'($urandom_range(0, 3)));
            send(1'b1, i, 1'b0);
        end
        idle(2);
        chk("t3_count", pq.size(), 1);
        check_pulse("t3", 0, 8, 7, 36);
        pq.delete();

        // 4: restart with a valid sample after a partial frame
        repeat (5) send(1'b1, 9, 1'b0);
        send(1'b1, 4, 1'b1);
        repeat (7) send(1'b1, 2, 1'b0);
        idle(2);
        chk("t4_count", pq.size(), 1);
        check_pulse("t4", 0, 4, 0, 18);
        pq.delete();

        // Restart coinciding with the last bin: no pulse, sample starts new frame
        repeat (7) send(1'b1, 6, 1'b0);
        send(1'b1, 3, 1'b1);
        idle(1);
        chk("rl_no_pulse", pq.size(), 0);
        chk("rl_held_mag", peak_mag, 4);
        repeat (7) send(1'b1, 1, 1'b0);
        idle(2);
        chk("rl_count", pq.size(), 1);
        check_pulse("rl", 0, 3, 0, 10);
        pq.delete();

        // 5: reset in mid-frame, then a frame of ones
        repeat (6) send(1'b1, 5, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        data_in_ready = 1'b0;
        @(negedge clk);
        chk("t5_rst_mag", peak_mag, 0);
        chk("t5_rst_bin", peak_bin, 0);
        chk("t5_rst_sum", frame_sum, 0);
        rst = 1'b1;
        repeat (FL) send(1'b1, 1, 1'b0);
        idle(2);
        chk("t5_count", pq.size(), 1);
        check_pulse("t5", 0, 1, 0, 8);
        pq.delete();

`ifdef PEAK_THRESHOLD_EN
        // 6: threshold at and above the peak
        threshold = DW'(9);
        foreach (t1_data[i]) send(1'b1, t1_data[i], 1'b0);
        idle(2);
        chk("t6a_count", pq.size(), 1);
        if (pq.size() >= 1) chk("t6a_thr", pq[0].thr, 1);
        pq.delete();
        threshold = DW'(10);
        foreach (t1_data[i]) send(1'b1, t1_data[i], 1'b0);
        idle(2);
        chk("t6b_count", pq.size(), 1);
        if (pq.size() >= 1) chk("t6b_thr", pq[0].thr, 0);
        pq.delete();
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
